// File: rtl/march_bist_controller.sv
// March C- BIST sequencer: drives an external address generator and RAM port, compares reads, captures first fail.
// Optional BIST_STOP_ON_FAIL_EN: abort the run on the first miscompare.
module march_bist_controller #(
    parameter int AW = 4,
    parameter int DW = 8,
    parameter int CW = 8
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    output logic          busy,
    output logic          done,
    output logic          ag_clr,
    output logic          ag_preset,
    output logic          ag_en,
    output logic          ag_up_down,
    input  logic [AW-1:0] ag_address,
    input  logic          ag_carry,
    output logic          mem_cs,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    output logic          fail,
    output logic [AW-1:0] fail_addr,
    output logic [2:0]    fail_element,
    output logic [CW-1:0] fail_count
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_SETUP = 3'd1,
        S_OP0   = 3'd2,
        S_OP1   = 3'd3,
        S_DRAIN = 3'd4,
        S_DONE  = 3'd5
    } state_t;

    state_t        state_r;
    state_t        state_seq_s;
    state_t        state_s;
    logic [2:0]    elem_r;
    logic [2:0]    elem_s;

    logic          busy_s;
    logic          done_s;
    logic          clr_s;
    logic          preset_s;
    logic          en_s;
    logic          ud_s;
    logic          cs_s;
    logic          we_s;
    logic [DW-1:0] wdata_s;

    logic          cmp_valid_r;
    logic [DW-1:0] cmp_exp_r;
    logic [2:0]    cmp_elem_r;
    logic [AW-1:0] cmp_addr_r;
    logic          miscmp_s;
    logic          start_acc_s;
    logic          rd_now_s;

    // M3 and M4 walk the array downwards, all others upwards.
    function automatic logic elem_down(input logic [2:0] e);
        return (e == 3'd3) || (e == 3'd4);
    endfunction

    function automatic logic elem_two_ops(input logic [2:0] e);
        return (e != 3'd0) && (e != 3'd5);
    endfunction

    // Background expected by the read of an element: all-1 after M1/M3 wrote ones.
    function automatic logic read_bg(input logic [2:0] e);
        return (e == 3'd2) || (e == 3'd4);
    endfunction

    assign mem_addr    = ag_address;
    assign start_acc_s = (state_r == S_IDLE) && start;
    assign rd_now_s    = (state_r == S_OP0) && (elem_r != 3'd0);
    assign miscmp_s    = cmp_valid_r && (mem_rdata != cmp_exp_r);

    // State, element index and registered outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r    <= S_IDLE;
            elem_r     <= 3'd0;
            busy       <= 1'b0;
            done       <= 1'b0;
            ag_clr     <= 1'b0;
            ag_preset  <= 1'b0;
            ag_en      <= 1'b0;
            ag_up_down <= 1'b0;
            mem_cs     <= 1'b0;
            mem_we     <= 1'b0;
            mem_wdata  <= {DW{1'b0}};
        end else begin
            state_r    <= state_s;
            elem_r     <= elem_s;
            busy       <= busy_s;
            done       <= done_s;
            ag_clr     <= clr_s;
            ag_preset  <= preset_s;
            ag_en      <= en_s;
            ag_up_down <= ud_s;
            mem_cs     <= cs_s;
            mem_we     <= we_s;
            mem_wdata  <= wdata_s;
        end
    end

    // Next-state sequencing through the six march elements.
    always_comb begin
        state_seq_s = state_r;
        elem_s      = elem_r;
        case (state_r)
            S_IDLE: begin
                if (start) begin
                    state_seq_s = S_SETUP;
                    elem_s      = 3'd0;
                end else begin
                    state_seq_s = S_IDLE;
                end
            end
            S_SETUP: state_seq_s = S_OP0;
            S_OP0, S_OP1: begin
                if ((state_r == S_OP0) && elem_two_ops(elem_r)) begin
                    state_seq_s = S_OP1;
                end else if (!ag_carry) begin
                    state_seq_s = S_OP0;
                end else if (elem_r == 3'd5) begin
                    state_seq_s = S_DRAIN;
                end else begin
                    state_seq_s = S_SETUP;
                    elem_s      = elem_r + 3'd1;
                end
            end
            S_DRAIN: state_seq_s = S_DONE;
            S_DONE:  state_seq_s = S_IDLE;
            default: state_seq_s = S_IDLE;
        endcase
    end

`ifdef BIST_STOP_ON_FAIL_EN
    assign state_s = miscmp_s ? S_DONE : state_seq_s;
`else
    assign state_s = state_seq_s;
`endif

    // Output decode of the upcoming state so every output leaves a flop.
    always_comb begin
        busy_s   = 1'b0;
        done_s   = 1'b0;
        clr_s    = 1'b0;
        preset_s = 1'b0;
        en_s     = 1'b0;
        ud_s     = 1'b0;
        cs_s     = 1'b0;
        we_s     = 1'b0;
        wdata_s  = {DW{1'b0}};
        case (state_s)
            S_SETUP: begin
                busy_s = 1'b1;
                ud_s   = ~elem_down(elem_s);
                if (elem_down(elem_s)) begin
                    preset_s = 1'b1;
                end else begin
                    clr_s = 1'b1;
                end
            end
            S_OP0: begin
                busy_s = 1'b1;
                ud_s   = ~elem_down(elem_s);
                cs_s   = 1'b1;
                we_s   = (elem_s == 3'd0);
                en_s   = ~elem_two_ops(elem_s);
            end
            S_OP1: begin
                busy_s  = 1'b1;
                ud_s    = ~elem_down(elem_s);
                cs_s    = 1'b1;
                we_s    = 1'b1;
                wdata_s = {DW{elem_s[0]}};
                en_s    = 1'b1;
            end
            S_DRAIN: busy_s = 1'b1;
            S_DONE:  done_s = 1'b1;
            S_IDLE:  busy_s = 1'b0;
            default: busy_s = 1'b0;
        endcase
    end

    // Read data arrives a cycle late, so the expectation travels with it.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cmp_valid_r <= 1'b0;
            cmp_exp_r   <= {DW{1'b0}};
            cmp_elem_r  <= 3'd0;
            cmp_addr_r  <= {AW{1'b0}};
        end else begin
            cmp_valid_r <= rd_now_s;
            cmp_exp_r   <= {DW{read_bg(elem_r)}};
            cmp_elem_r  <= elem_r;
            cmp_addr_r  <= ag_address;
        end
    end

    // Sticky fail status with first-fail capture and saturating count.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            fail         <= 1'b0;
            fail_addr    <= {AW{1'b0}};
            fail_element <= 3'd0;
            fail_count   <= {CW{1'b0}};
        end else if (start_acc_s) begin
            fail         <= 1'b0;
            fail_addr    <= {AW{1'b0}};
            fail_element <= 3'd0;
            fail_count   <= {CW{1'b0}};
        end else if (miscmp_s) begin
            fail <= 1'b1;
            if (!fail) begin
                fail_addr    <= cmp_addr_r;
                fail_element <= cmp_elem_r;
            end
            if (fail_count != {CW{1'b1}}) begin
                fail_count <= fail_count + {{(CW-1){1'b0}}, 1'b1};
            end
        end
    end

endmodule

// File: tb/tb_march_bist_controller.sv
// Bench for march_bist_controller: generator + faulty RAM models, March C- op-trace model, directed runs.
module tb_march_bist_controller;
    localparam int AW = 4;
    localparam int DW = 8;
    localparam int CW = 8;
    localparam int N  = 16;
`ifdef BIST_STOP_ON_FAIL_EN
    localparam bit STOP_MODE = 1'b1;
`else
    localparam bit STOP_MODE = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          start = 1'b0;
    logic          busy, done, ag_clr, ag_preset, ag_en, ag_up_down;
    logic [AW-1:0] ag_address;
    logic          ag_carry;
    logic          mem_cs, mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;
    logic          fail;
    logic [AW-1:0] fail_addr;
    logic [2:0]    fail_element;
    logic [CW-1:0] fail_count;

    march_bist_controller #(.AW(AW), .DW(DW), .CW(CW)) dut (
        .clk(clk), .reset(reset), .start(start), .busy(busy), .done(done),
        .ag_clr(ag_clr), .ag_preset(ag_preset), .ag_en(ag_en), .ag_up_down(ag_up_down),
        .ag_address(ag_address), .ag_carry(ag_carry),
        .mem_cs(mem_cs), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .fail(fail), .fail_addr(fail_addr),
        .fail_element(fail_element), .fail_count(fail_count)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic          we;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } op_t;

    op_t           exp_q[$];
    op_t           cur_op;
    logic [DW-1:0] ram [N];
    logic [DW-1:0] sa1 [N];
    logic [DW-1:0] sa0 [N];
    int            n_cmp = 0;
    int            n_bad = 0;
    int            exp_busy;
    int            exp_fcnt;
    bit            exp_fail;
    logic [AW-1:0] exp_faddr;
    logic [2:0]    exp_felem;
    int            busy_cnt = 0;
    int            done_cnt = 0;
    bit            checking = 1'b0;

    // Address generator model.
    always @(posedge clk or negedge reset) begin
        if (!reset)          ag_address <= '0;
        else if (ag_clr)     ag_address <= '0;
        else if (ag_preset)  ag_address <= '1;
        else if (ag_en)      ag_address <= ag_up_down ? ag_address + 4'd1 : ag_address - 4'd1;
    end
    assign ag_carry = ag_up_down ? (ag_address == 4'hF) : (ag_address == 4'h0);

    // RAM with stuck-at masks applied on read.
    always @(posedge clk) begin
        if (mem_cs && mem_we)  ram[mem_addr] <= mem_wdata;
        if (mem_cs && !mem_we) mem_rdata <= (ram[mem_addr] | sa1[mem_addr]) & ~sa0[mem_addr];
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
        n_cmp++;
        if (act !== expv) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, expv);
        end
    endtask

    task automatic clear_faults();
        for (int i = 0; i < N; i++) begin
            sa1[i] = '0;
            sa0[i] = '0;
        end
    endtask

    // March C- op list, then the expected fail outcome from the fault masks.
    task automatic build_expected();
        op_t           full[$];
        int            elem_of[$];
        int            first_idx;
        int            last;
        logic [DW-1:0] obs;
        full.delete();
        elem_of.delete();
        exp_q.delete();
        first_idx = -1;
        exp_fail  = 1'b0;
        exp_faddr = '0;
        exp_felem = '0;
        exp_fcnt  = 0;
        for (int e = 0; e < 6; e++) begin
            for (int k = 0; k < N; k++) begin
                int a;
                op_t o;
                a = (e == 3 || e == 4) ? N - 1 - k : k;
                if (e != 0) begin
                    o.we = 1'b0; o.addr = a[AW-1:0];
                    o.data = (e == 2 || e == 4) ? '1 : '0;
                    full.push_back(o); elem_of.push_back(e);
                end
                if (e != 5) begin
                    o.we = 1'b1; o.addr = a[AW-1:0];
                    o.data = (e == 1 || e == 3) ? '1 : '0;
                    full.push_back(o); elem_of.push_back(e);
                end
            end
        end
        for (int i = 0; i < full.size(); i++) begin
            if (!full[i].we) begin
                obs = (full[i].data | sa1[full[i].addr]) & ~sa0[full[i].addr];
                if (obs != full[i].data) begin
                    if (!exp_fail) begin
                        exp_fail  = 1'b1;
                        exp_faddr = full[i].addr;
                        exp_felem = 3'(elem_of[i]);
                        first_idx = i;
                    end
                    if (exp_fcnt < 255) exp_fcnt++;
                end
            end
        end
        last = full.size() - 1;
        if (STOP_MODE && first_idx >= 0) begin
            last     = (first_idx + 1 < full.size()) ? first_idx + 1 : first_idx;
            exp_fcnt = 1;
        end
        for (int i = 0; i <= last; i++) exp_q.push_back(full[i]);
        exp_busy = (elem_of[last] + 1) + (last + 1) + ((last == full.size() - 1) ? 1 : 0);
    endtask

    // Per-cycle check of memory traffic against the op model; busy/done tally.
    always @(negedge clk) begin
        if (checking) begin
            if (busy) busy_cnt++;
            if (done) done_cnt++;
            if (mem_cs) begin
                if (exp_q.size() == 0) begin
                    chk("extra_mem_op", 32'd1, 32'd0);
                end else begin
                    cur_op = exp_q.pop_front();
                    chk("mem_we", 32'(mem_we), 32'(cur_op.we));
                    chk("mem_addr", 32'(mem_addr), 32'(cur_op.addr));
                    if (cur_op.we) chk("mem_wdata", 32'(mem_wdata), 32'(cur_op.data));
                end
            end
        end
    end

    task automatic run_and_check(input string nm, input bit repulse);
        bit seen;
        build_expected();
        busy_cnt = 0;
        done_cnt = 0;
        @(posedge clk);
        checking = 1'b1;
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 400 && !seen; i++) begin
            @(negedge clk);
            seen  = done;
            start = repulse && (i == 20 || i == 90);
        end
        start = 1'b0;
        chk({nm, "_done_seen"}, 32'(seen), 32'd1);
        repeat (4) @(negedge clk);
        @(posedge clk);
        checking = 1'b0;
        chk({nm, "_busy_cycles"}, busy_cnt, exp_busy);
        chk({nm, "_done_pulses"}, done_cnt, 32'd1);
        chk({nm, "_ops_left"}, exp_q.size(), 32'd0);
        chk({nm, "_fail"}, 32'(fail), 32'(exp_fail));
        chk({nm, "_fail_addr"}, 32'(fail_addr), 32'(exp_faddr));
        chk({nm, "_fail_element"}, 32'(fail_element), 32'(exp_felem));
        chk({nm, "_fail_count"}, 32'(fail_count), exp_fcnt);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        clear_faults();
        for (int i = 0; i < N; i++) ram[i] = '0;
        repeat (3) @(negedge clk);
        chk("reset_outputs",
            {13'd0, busy, done, ag_clr, ag_preset, ag_en, ag_up_down, mem_cs, mem_we, fail, fail_element, fail_addr},
            32'd0);
        chk("reset_count_wdata", {16'd0, fail_count, mem_wdata}, 32'd0);
        reset = 1'b1;
        repeat (2) @(negedge clk);

        // 1: fault-free run
        run_and_check("t1_clean", 1'b0);
        chk("t1_model_busy_167", exp_busy, 32'd167);
        chk("t1_dut_busy_167", busy_cnt, 32'd167);

        // 2: bit0 stuck-at-1 at address 5
        sa1[5] = 8'h01;
        run_and_check("t2_sa1", 1'b0);
        chk("t2_fail_addr_lit", 32'(fail_addr), 32'd5);
        chk("t2_fail_elem_lit", 32'(fail_element), 32'd1);
        chk("t2_fail_count_lit", 32'(fail_count), STOP_MODE ? 32'd1 : 32'd3);
        chk("t2_busy_lit", busy_cnt, STOP_MODE ? 32'd30 : 32'd167);
        clear_faults();

        // 3: bit7 stuck-at-0 at address 12
        sa0[12] = 8'h80;
        run_and_check("t3_sa0", 1'b0);
        chk("t3_fail_lit", 32'(fail), 32'd1);
        chk("t3_fail_addr_lit", 32'(fail_addr), 32'd12);
        chk("t3_fail_elem_lit", 32'(fail_element), 32'd2);
        chk("t3_fail_count_lit", 32'(fail_count), STOP_MODE ? 32'd1 : 32'd2);

        // 4: reset during M3 with a live fault, then a clean run
        sa1[5] = 8'h01;
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        repeat (90) @(negedge clk);
        chk("t4_fail_before_reset", 32'(fail), 32'd1);
        reset = 1'b0;
        #1;
        chk("t4_outputs_in_reset",
            {13'd0, busy, done, ag_clr, ag_preset, ag_en, ag_up_down, mem_cs, mem_we, fail, fail_element, fail_addr},
            32'd0);
        chk("t4_count_in_reset", {24'd0, fail_count}, 32'd0);
        @(negedge clk);
        reset = 1'b1;
        clear_faults();
        repeat (2) @(negedge clk);
        chk("t4_idle_after_reset", {30'd0, busy, done}, 32'd0);
        run_and_check("t4_clean", 1'b0);

        // 5: start re-pulsed while busy is ignored
        run_and_check("t5_repulse", 1'b1);
        chk("t5_busy_167", busy_cnt, 32'd167);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
